// File: rtl/riscv_dcache_pkg.sv
// riscv_dcache_pkg
// Shared types and helpers for the RV64I L1 data-cache controller.
//   dcacheState_e  : controller FSM states. FLUSH exists only when
//                    RISCV_DCACHE_FLUSH_EN is defined.
//   coreOp_e       : single request picked from the core's request levels.
//   SIZE_*         : access size codes (B/H/W/D).
//   calcStrobe     : byte-lane strobe for an access within an 8-byte word.
//   isMisaligned   : alignment fault check (plain or atomic access).
package riscv_dcache_pkg;

`ifdef RISCV_DCACHE_FLUSH_EN
  typedef enum logic [2:0] {
    IDLE, REFILL, FILL, AMO_RD, WRITE_WAIT, FLUSH
  } dcacheState_e;
`else
  typedef enum logic [2:0] {
    IDLE, REFILL, FILL, AMO_RD, WRITE_WAIT
  } dcacheState_e;
`endif

  typedef enum logic [2:0] {
    OP_NONE, OP_READ, OP_LR, OP_WRITE, OP_SC, OP_AMO
  } coreOp_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  // Base lane mask shifted by the byte offset; lanes beyond byte 7 fall off.
  function automatic logic [7:0] calcStrobe(input logic [1:0] size,
                                            input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SIZE_B:  base = 8'h01;
      SIZE_H:  base = 8'h03;
      SIZE_W:  base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Plain accesses fault only when they would cross the 8-byte word.
  // Atomics must be naturally aligned words or doublewords.
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [2:0] off,
                                        input logic       atomic);
    logic fault;
    if (atomic) begin
      fault = !(((size == SIZE_W) && (off[1:0] == 2'b00)) ||
                ((size == SIZE_D) && (off == 3'd0)));
    end else begin
      case (size)
        SIZE_B:  fault = 1'b0;
        SIZE_H:  fault = (off == 3'd7);
        SIZE_W:  fault = (off > 3'd4);
        default: fault = (off != 3'd0);
      endcase
    end
    return fault;
  endfunction

endpackage

// File: rtl/riscv_core_dcache_ctrl_nway_tag_array.sv
// riscv_dcache_tag_array
// Per-way tag/valid storage with hit detection, victim selection and
// per-set round-robin replacement pointers.
//   clk_i, rst_ni      : clock, synchronous active-low reset (clears valids, RR)
//   index_i, tag_i     : set index and tag of the current request
//   fill_i             : write tag_i into the victim way of index_i, bump RR
//   flush_i            : clear every way's valid bit in set flushIndex_i
//   hit_o, hitWay_o    : lookup result and encoded hit way
//   victimWay_o        : lowest invalid way, else the set's RR pointer
//   victimValid_o/Tag_o: current contents of the victim way (eviction check)
module riscv_dcache_tag_array #(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_W       = 52,
  parameter int WAY_W       = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [INDEX_WIDTH-1:0] index_i,
  input  logic [TAG_W-1:0]       tag_i,
  input  logic                   fill_i,
  input  logic                   flush_i,
  input  logic [INDEX_WIDTH-1:0] flushIndex_i,
  output logic                   hit_o,
  output logic [WAY_W-1:0]       hitWay_o,
  output logic [WAY_W-1:0]       victimWay_o,
  output logic                   victimValid_o,
  output logic [TAG_W-1:0]       victimTag_o
);

  localparam int SETS = 2 ** INDEX_WIDTH;

  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [SETS-1:0]  valid_q [WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [WAYS-1:0]  hitVec;
  logic [WAY_W-1:0] nextRr;

  // Compare all ways of the indexed set; at most one can match.
  always_comb begin
    hitVec   = '0;
    hitWay_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      hitVec[w] = valid_q[w][index_i] && (tag_q[w][index_i] == tag_i);
      if (hitVec[w]) hitWay_o = WAY_W'(w);
    end
  end

  assign hit_o = |hitVec;

  // Scanning downwards leaves the lowest invalid way selected; a full set
  // falls back to the round-robin pointer.
  always_comb begin
    victimWay_o = rr_q[index_i];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][index_i]) victimWay_o = WAY_W'(w);
    end
  end

  assign victimValid_o = valid_q[victimWay_o][index_i];
  assign victimTag_o   = tag_q[victimWay_o][index_i];
  assign nextRr = (rr_q[index_i] == WAY_W'(WAYS - 1)) ? '0 : rr_q[index_i] + 1'b1;

  // Valid bits and RR pointers: reset, fill and flush updates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      if (fill_i) begin
        valid_q[victimWay_o][index_i] <= 1'b1;
        rr_q[index_i]                 <= nextRr;
      end
      if (flush_i) begin
        for (int w = 0; w < WAYS; w++) valid_q[w][flushIndex_i] <= 1'b0;
      end
    end
  end

  // Tags need no reset: they are only ever used qualified by valid.
  always_ff @(posedge clk_i) begin
    if (fill_i) tag_q[victimWay_o][index_i] <= tag_i;
  end

endmodule

// File: rtl/riscv_core_dcache_ctrl_nway.sv
// riscv_core_dcache_ctrl_nway
// WAYS-way set-associative, write-through L1 data-cache controller for the
// RV64I core: hit/miss, line refill, store write-through, LR/SC reservation,
// AMO read-modify-write and misalignment faults.
// Optional feature: RISCV_DCACHE_FLUSH_EN enables i_flush (invalidate-all,
// one set per cycle). Without it i_flush is ignored.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_addr/data_from_core, i_size  request address, store data, size code
//   i_read/i_write/i_lr/i_sc/i_amo request levels (held while o_stall)
//   i_amo_alu_result               AMO result written back and through
//   i_flush                        invalidate-all request
//   o_stall, o_*_fault, o_sc_result  core-side status
//   o_rd_en/o_wr_en/o_way_sel/o_block_replace/o_amo_wr  data-array control
//   o_mem_read_req/address, i_mem_read_done             refill interface
//   o_mem_write_valid/address/data/strobe, i_mem_write_done  write-through
module riscv_core_dcache_ctrl_nway
  import riscv_dcache_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 7,
  parameter int LINE_BYTES  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic [DATA_WIDTH-1:0] i_data_from_core,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic                  i_lr,
  input  logic                  i_sc,
  input  logic                  i_amo,
  input  logic [1:0]            i_size,
  input  logic [DATA_WIDTH-1:0] i_amo_alu_result,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_load_fault,
  output logic                  o_store_fault,
  output logic                  o_amo_fault,
  output logic [DATA_WIDTH-1:0] o_sc_result,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic [WAY_W-1:0]      o_way_sel,
  output logic                  o_block_replace,
  output logic                  o_amo_wr,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  input  logic                  i_mem_read_done,
  output logic                  o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_write_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  output logic [7:0]            o_mem_write_strobe,
  input  logic                  i_mem_write_done
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W;
  localparam int LINE_W   = ADDR_WIDTH - OFFSET_W;

  dcacheState_e state_q, state_d;
  coreOp_e      op;

  logic                   amoPend_q, amoPend_d;
  logic                   resValid_q, resValid_d;
  logic [ADDR_WIDTH-1:0]  resAddr_q, resAddr_d;
  logic [1:0]             resSize_q, resSize_d;

  logic [INDEX_WIDTH-1:0] reqIndex;
  logic [TAG_W-1:0]       reqTag;
  logic [LINE_W-1:0]      reqLine;
  logic [2:0]             reqOff;
  logic                   hit, victimValid, fillEn, opFault, scMatch, scFail;
  logic [WAY_W-1:0]       hitWay, victimWay;
  logic [TAG_W-1:0]       victimTag;
  logic                   flushEn;
  logic [INDEX_WIDTH-1:0] flushIdx;

  assign reqIndex = i_addr_from_core[OFFSET_W +: INDEX_WIDTH];
  assign reqTag   = i_addr_from_core[ADDR_WIDTH-1 -: TAG_W];
  assign reqLine  = i_addr_from_core[ADDR_WIDTH-1:OFFSET_W];
  assign reqOff   = i_addr_from_core[2:0];

  assign scMatch = resValid_q && (resAddr_q == i_addr_from_core) && (resSize_q == i_size);

  assign o_sc_result         = {{(DATA_WIDTH-1){1'b0}}, scFail};
  assign o_way_sel           = hit ? hitWay : victimWay;
  assign o_mem_read_address  = {reqLine, {OFFSET_W{1'b0}}};
  assign o_mem_write_address = i_addr_from_core;
  assign o_mem_write_data    = amoPend_q ? i_amo_alu_result : i_data_from_core;
  assign o_mem_write_strobe  = calcStrobe(i_size, reqOff);

  riscv_dcache_tag_array #(
    .WAYS        (WAYS),
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_W       (TAG_W),
    .WAY_W       (WAY_W)
  ) u_tag_array (
    .clk_i         (i_clk),
    .rst_ni        (i_rst_n),
    .index_i       (reqIndex),
    .tag_i         (reqTag),
    .fill_i        (fillEn),
    .flush_i       (flushEn),
    .flushIndex_i  (flushIdx),
    .hit_o         (hit),
    .hitWay_o      (hitWay),
    .victimWay_o   (victimWay),
    .victimValid_o (victimValid),
    .victimTag_o   (victimTag)
  );

  // Pick one request: read > lr > write > sc > amo.
  always_comb begin
    op = OP_NONE;
    if (i_read)       op = OP_READ;
    else if (i_lr)    op = OP_LR;
    else if (i_write) op = OP_WRITE;
    else if (i_sc)    op = OP_SC;
    else if (i_amo)   op = OP_AMO;
  end

  // LR/SC/AMO use the stricter atomic alignment rule.
  always_comb begin
    case (op)
      OP_READ, OP_WRITE:   opFault = isMisaligned(i_size, reqOff, 1'b0);
      OP_LR, OP_SC, OP_AMO: opFault = isMisaligned(i_size, reqOff, 1'b1);
      default:             opFault = 1'b0;
    endcase
  end

`ifdef RISCV_DCACHE_FLUSH_EN
  logic [INDEX_WIDTH-1:0] flushCnt_q, flushCnt_d;
  assign flushIdx = flushCnt_q;

  // Flush walk counter; wraps back to zero after the last set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) flushCnt_q <= '0;
    else          flushCnt_q <= flushCnt_d;
  end
`else
  logic unusedFlush;
  assign unusedFlush = i_flush;
  assign flushEn     = 1'b0;
  assign flushIdx    = '0;
`endif

  // Next-state and output decode. Everything stays at its default while
  // reset is asserted so no array or memory action leaks out of reset.
  always_comb begin
    state_d         = state_q;
    amoPend_d       = amoPend_q;
    resValid_d      = resValid_q;
    resAddr_d       = resAddr_q;
    resSize_d       = resSize_q;
    o_stall         = 1'b0;
    o_load_fault    = 1'b0;
    o_store_fault   = 1'b0;
    o_amo_fault     = 1'b0;
    scFail          = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_amo_wr        = 1'b0;
    o_mem_read_req  = 1'b0;
    o_mem_write_valid = 1'b0;
    fillEn          = 1'b0;
`ifdef RISCV_DCACHE_FLUSH_EN
    flushEn         = 1'b0;
    flushCnt_d      = flushCnt_q;
`endif
    if (i_rst_n) begin
      case (state_q)
        IDLE: begin
          case (op)
            OP_READ, OP_LR: begin
              if (opFault) begin
                o_load_fault = 1'b1;
              end else if (hit) begin
                o_rd_en = 1'b1;
                if (op == OP_LR) begin
                  resValid_d = 1'b1;
                  resAddr_d  = i_addr_from_core;
                  resSize_d  = i_size;
                end
              end else begin
                o_stall        = 1'b1;
                o_mem_read_req = 1'b1;
                state_d        = REFILL;
              end
            end
            OP_WRITE, OP_SC: begin
              if (opFault) begin
                o_store_fault = 1'b1;
                if (op == OP_SC) resValid_d = 1'b0;
              end else if ((op == OP_SC) && !scMatch) begin
                // Failed SC completes at once, without touching memory.
                scFail     = 1'b1;
                resValid_d = 1'b0;
              end else if (hit) begin
                o_wr_en           = 1'b1;
                o_mem_write_valid = 1'b1;
                o_stall           = 1'b1;
                state_d           = WRITE_WAIT;
                if ((op == OP_SC) || (resValid_q && (resAddr_q[ADDR_WIDTH-1:OFFSET_W] == reqLine)))
                  resValid_d = 1'b0;
              end else begin
                o_stall        = 1'b1;
                o_mem_read_req = 1'b1;
                state_d        = REFILL;
              end
            end
            OP_AMO: begin
              if (opFault) begin
                o_amo_fault = 1'b1;
              end else if (hit) begin
                o_rd_en   = 1'b1;
                o_stall   = 1'b1;
                amoPend_d = 1'b1;
                state_d   = AMO_RD;
              end else begin
                o_stall        = 1'b1;
                o_mem_read_req = 1'b1;
                state_d        = REFILL;
              end
            end
            default: begin
`ifdef RISCV_DCACHE_FLUSH_EN
              if (i_flush) begin
                o_stall = 1'b1;
                state_d = FLUSH;
              end
`endif
            end
          endcase
        end
        REFILL: begin
          o_stall        = 1'b1;
          o_mem_read_req = 1'b1;
          if (i_mem_read_done) state_d = FILL;
        end
        FILL: begin
          // The request is still held, so the lookup now targets the victim.
          o_stall         = 1'b1;
          o_wr_en         = 1'b1;
          o_block_replace = 1'b1;
          fillEn          = 1'b1;
          if (resValid_q && victimValid &&
              ({victimTag, reqIndex} == resAddr_q[ADDR_WIDTH-1:OFFSET_W]))
            resValid_d = 1'b0;
          state_d = IDLE;
        end
        AMO_RD: begin
          o_stall = 1'b1;
          state_d = WRITE_WAIT;
        end
        WRITE_WAIT: begin
          o_stall           = 1'b1;
          o_mem_write_valid = 1'b1;
          o_amo_wr          = amoPend_q;
          if (i_mem_write_done) begin
            o_stall   = 1'b0;
            o_wr_en   = amoPend_q;
            amoPend_d = 1'b0;
            state_d   = IDLE;
          end
        end
`ifdef RISCV_DCACHE_FLUSH_EN
        FLUSH: begin
          // Stall drops on the last set so the core releases i_flush before
          // the FSM is back in IDLE.
          o_stall    = 1'b1;
          flushEn    = 1'b1;
          flushCnt_d = flushCnt_q + 1'b1;
          resValid_d = 1'b0;
          if (flushCnt_q == '1) begin
            o_stall = 1'b0;
            state_d = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state, pending-AMO flag and LR reservation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      amoPend_q  <= 1'b0;
      resValid_q <= 1'b0;
      resAddr_q  <= '0;
      resSize_q  <= '0;
    end else begin
      state_q    <= state_d;
      amoPend_q  <= amoPend_d;
      resValid_q <= resValid_d;
      resAddr_q  <= resAddr_d;
      resSize_q  <= resSize_d;
    end
  end

endmodule
